// File: rtl/cnn_pkg.sv
// Shared defaults and FSM state type for the CNN window path.
package cnn_pkg;
  localparam int PIX_W_DEF = 8;
  localparam int X_W_DEF   = 11;
  localparam int Y_W_DEF   = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/win_col_shift.sv
// 3-deep column register feeding a 3x3 window; col2 takes the newest column.
module win_col_shift
  import cnn_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               shift_en,
  input  logic [3*PIX_W-1:0] col_in,
  output logic [9*PIX_W-1:0] win
);

  // Each column packs row0 (top) in its most significant pixel slot.
  logic [3*PIX_W-1:0] r_col [0:2];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_col[0] <= '0;
      r_col[1] <= '0;
      r_col[2] <= '0;
    end else if (shift_en) begin
      r_col[0] <= r_col[1];
      r_col[1] <= r_col[2];
      r_col[2] <= col_in;
    end
  end

  always_comb begin
    win = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win[PIX_W*(3*r+c) +: PIX_W] = r_col[c][PIX_W*(2-r) +: PIX_W];
      end
    end
  end

endmodule

// File: rtl/window_gen_3x3.sv
// Column stream to registered 3x3 window with qualification, count and frame FSM.
// Optional WIN_STRIDE2_EN adds a stride2 input restricting windows to even origins.
module window_gen_3x3
  import cnn_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int X_W   = X_W_DEF,
  parameter int Y_W   = Y_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               in_valid,
`ifdef WIN_STRIDE2_EN
  input  logic               stride2,
`endif
  input  logic [PIX_W-1:0]   row0,
  input  logic [PIX_W-1:0]   row1,
  input  logic [PIX_W-1:0]   row2,
  input  logic [X_W-1:0]     x_in,
  input  logic [Y_W-1:0]     y_in,
  input  logic [7:0]         img_width,
  input  logic [Y_W-1:0]     img_height,
  output logic [9*PIX_W-1:0] win,
  output logic               win_valid,
  output logic [X_W-1:0]     win_x,
  output logic [Y_W-1:0]     win_y,
  output logic [15:0]        win_count,
  output logic               frame_done,
  output logic               coord_err
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t             r_state;
  logic [X_W-1:0]     w_width;
  logic               w_in_range;
  logic               w_accept;
  logic               w_oob;
  logic               w_stride_ok;
  logic               w_qual;
  logic               w_last;
  logic               w_start;
  logic [15:0]        w_count_base;
  logic [3*PIX_W-1:0] w_col;

  assign w_width    = X_W'(img_width);
  assign w_in_range = (x_in < w_width) && (y_in < img_height);
  assign w_accept   = in_valid && w_in_range && !clear;
  assign w_oob      = in_valid && !w_in_range;
  assign w_col      = {row0, row1, row2};

`ifdef WIN_STRIDE2_EN
  logic r_stride2;
  logic w_stride;
  // The live port is honoured only while idle; a running frame uses the latched value.
  assign w_stride    = (r_state == ST_IDLE) ? stride2 : r_stride2;
  assign w_stride_ok = !w_stride || (!x_in[0] && !y_in[0]);

  always_ff @(posedge clk) begin
    if (reset) r_stride2 <= 1'b0;
    else if (r_state == ST_IDLE) r_stride2 <= stride2;
  end
`else
  assign w_stride_ok = 1'b1;
`endif

  // Stale columns at x=0/1 are masked purely by the x>=2 test.
  assign w_qual  = w_accept && (x_in >= X_W'(2)) && (y_in >= Y_W'(2)) && w_stride_ok;
  assign w_last  = w_accept && (x_in == w_width - X_W'(1)) && (y_in == img_height - Y_W'(1));
  assign w_start = w_accept && (r_state != ST_ACTIVE);
  assign w_count_base = w_start ? 16'd0 : win_count;

  win_col_shift #(.PIX_W(PIX_W)) u_cols (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .shift_en (w_accept),
    .col_in   (w_col),
    .win      (win)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      win_valid  <= 1'b0;
      win_x      <= '0;
      win_y      <= '0;
      win_count  <= '0;
      frame_done <= 1'b0;
      coord_err  <= 1'b0;
    end else if (clear) begin
      r_state    <= ST_IDLE;
      win_valid  <= 1'b0;
      win_count  <= '0;
      frame_done <= 1'b0;
      coord_err  <= 1'b0;
    end else begin
      win_valid  <= w_qual;
      if (w_qual) begin
        win_x <= x_in - X_W'(2);
        win_y <= y_in - Y_W'(2);
      end
      coord_err  <= coord_err | w_oob;
      frame_done <= (r_state == ST_DONE);
      win_count  <= w_qual ? sat_inc(w_count_base) : w_count_base;
      case (r_state)
        ST_IDLE:   if (w_accept) r_state <= w_last ? ST_DONE : ST_ACTIVE;
        ST_ACTIVE: if (w_last) r_state <= ST_DONE;
        ST_DONE:   r_state <= w_accept ? (w_last ? ST_DONE : ST_ACTIVE) : ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/window_gen_3x3.md
# window_gen_3x3

Converts the column stream from `line_buffer` into a registered 3x3 pixel window for the convolution engine. Each valid beat carries one vertical column of three pixels, from two rows above down to the current row. The block shifts the column into a 3-deep column register and qualifies windows that lie fully inside the image. It emits each window with its top-left coordinate, counts windows, and flags the end of the frame.

## Interface
- `PIX_W`, default 8: pixel width.
- `X_W`, default 11: column coordinate width.
- `Y_W`, default 10: row coordinate width.
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `clear`  in  1: synchronous flush between channels/layers.
- `in_valid`  in  1: column beat valid. Top level drives it as `pixel_valid` delayed one cycle.
- `row0`, `row1`, `row2`  in  PIX_W each: column pixels, top (oldest row) to bottom (current row).
- `x_in`  in  X_W: column coordinate of the beat.
- `y_in`  in  Y_W: row coordinate of the beat.
- `img_width`  in  8: image width W, 3..128.
- `img_height`  in  Y_W: image height H, at least 3.
- `win`  out  9*PIX_W: window. Pixel (r,c) sits at bits [PIX_W*(3r+c) +: PIX_W]; r=0 is the top row, c=0 the leftmost column.
- `win_valid`  out  1: window qualified.
- `win_x`  out  X_W: top-left column of the window.
- `win_y`  out  Y_W: top-left row of the window.
- `win_count`  out  16: windows emitted this frame.
- `frame_done`  out  1: one-cycle pulse at end of frame.
- `coord_err`  out  1: sticky, set by an out-of-range beat.

## Operation
- Accepted beat: `in_valid` high, `x_in < W`, `y_in < H`. An out-of-range beat is dropped: no shift, no window, `coord_err` set.
- On each accepted beat, every column register moves one place left (col1 to col0, col2 to col1) and `{row0,row1,row2}` loads into col2.
- Window qualification: the beat has `x_in >= 2` and `y_in >= 2`.
  - A qualified window drives `win_x = x_in-2` and `win_y = y_in-2`, zero-extended, never negative.
  - Beats at x=0 and x=1 leave stale columns from the previous row in the register. The `x_in >= 2` rule masks them; there is no explicit row-wrap logic.
- `win_count` increments on each `win_valid`. It saturates at 0xFFFF.
- State machine, encoded in the package:
  - IDLE: entered on reset, clear, or from DONE. Moves to ACTIVE on the first accepted beat, which is also processed normally.
  - ACTIVE: moves to DONE on the accepted beat with `x_in = W-1` and `y_in = H-1`.
  - DONE: asserts `frame_done` for one cycle, then returns to IDLE. `win_count` holds its value through DONE and clears on the next IDLE-to-ACTIVE transition.
- A beat arriving in DONE is processed and also starts the next frame: go straight to ACTIVE and clear `win_count`, so the new window counts as 1.
- Priority: reset > clear > beat.
  - `clear` zeroes all column registers, `win`, `win_valid`, `win_count` and `coord_err`, and returns to IDLE.
  - A `clear` that coincides with a beat drops the beat.
- Reset values: every output is 0, all column registers are 0, state is IDLE.

## Timing
- Latency is 1 cycle. The beat sampled at edge N drives `win`, `win_valid`, `win_x` and `win_y` after edge N. `win_valid` is high for exactly one cycle per qualified beat.
- No backpressure. Beats may arrive on consecutive cycles; a full-rate stream gives one window per cycle once x ≥ 2.
- `frame_done` is asserted one cycle after the last window's `win_valid`.
- `win` holds its value between valids. Consumers sample only while `win_valid` is high.
- A reset mid-frame takes effect at the next edge and discards the in-flight window.

## Configuration
- `WIN_STRIDE2_EN` defined:
  - Adds input port `stride2` (1 bit), which takes effect at a frame start (IDLE) only.
  - With `stride2` high, the window additionally requires `x_in-2` and `y_in-2` to both be even.
  - Column shifting is unchanged.
- Undefined: there is no `stride2` port and stride is fixed at 1.

## Structure
- `cnn_pkg` holds `PIX_W`, `X_W` and `Y_W` defaults, and the state typedef IDLE/ACTIVE/DONE.
- Sub-module `win_col_shift` holds the 3x3 register array with shift enable and synchronous clear. The top level holds the qualification logic, FSM, counter and error flag.

## Test plan
- Reset, then a 5x5 raster at full rate with pixel = 10*y+x.
  - Exactly 9 windows, `win_count` = 9.
  - First window is (0,0) with r0 = {0,1,2}, r1 = {10,11,12}, r2 = {20,21,22}.
  - `frame_done` pulses once, 1 cycle after the window at (2,2).
- Same 5x5 raster with `in_valid` gaps of 0–3 cycles: identical window contents and coordinates, each window exactly 1 cycle after its beat.
- `WIN_STRIDE2_EN` with `stride2` = 1 on a 6x6 raster: windows only at (0,0), (2,0), (0,2), (2,2), and `win_count` = 4.
- Beat with x=9 when W=8: no shift, no window, `coord_err` = 1 and stays set. After `clear`, `coord_err` = 0 and the state is IDLE.
- `clear` asserted mid-frame together with a qualified beat: no `win_valid` is produced. The next frame's first window at x=2 contains no pre-clear pixels.
- Reset asserted during a frame: all outputs are 0 on the next cycle, and the following 3x3 frame yields exactly 1 window at (0,0).
